// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: LC-3 effective-address generator (ADDR2 offset + ADDR1 base) behind a 2-entry skid buffer.
// Define ADDR_LSHF1_EN to shift the sign-extended offset left by one (LC-3b byte addressing).
module addr_gen_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ir,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] base_r,
   input  logic [1:0]       addr2_sel,
   input  logic             addr1_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] addr_out,
   output logic             addr_wrap
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, s_q, s_d, off_sx, off, base;
   logic [WIDTH:0] sum;
   logic [1:0] sel2;
   logic mw_q, mw_d, sw_q, sw_d, in_ready_q, in_ready_d, wrap, acc, con;
   // Selects are gated by in_valid so unknown selects on idle cycles stay contained.
   always_comb begin
      sel2 = in_valid ? addr2_sel : 2'b00;
      off_sx = sel2 == 2'b01 ? {{(WIDTH-6){ir[5]}}, ir[5:0]} :
               sel2 == 2'b10 ? {{(WIDTH-9){ir[8]}}, ir[8:0]} :
               sel2 == 2'b11 ? {{(WIDTH-11){ir[10]}}, ir[10:0]} : '0;
`ifdef ADDR_LSHF1_EN
      off = {off_sx[WIDTH-2:0], 1'b0};
`else
      off = off_sx;
`endif
      base = (in_valid && addr1_sel) ? base_r : pc;
      sum = {1'b0, base} + {1'b0, off};
      wrap = sum[WIDTH] ^ off[WIDTH-1];
   end
   assign out_valid = state_q != EMPTY;
   assign in_ready = in_ready_q;
   assign addr_out = m_q;
   assign addr_wrap = mw_q;
   always_comb begin
      acc = in_valid && in_ready_q;
      con = out_valid && out_ready;
      state_d = state_q;
      m_d = m_q;
      mw_d = mw_q;
      s_d = s_q;
      sw_d = sw_q;
      case (state_q)
         EMPTY: if (acc) begin
            state_d = ONE;
            m_d = sum[WIDTH-1:0];
            mw_d = wrap;
         end
         ONE: if (acc && con) begin
            m_d = sum[WIDTH-1:0];
            mw_d = wrap;
         end else if (acc) begin
            state_d = TWO;
            s_d = sum[WIDTH-1:0];
            sw_d = wrap;
         end else if (con) begin
            state_d = EMPTY;
         end
         TWO: if (con) begin
            state_d = ONE;
            m_d = s_q;
            mw_d = sw_q;
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d = state_d != TWO;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= EMPTY;
         m_q <= '0;
         mw_q <= 1'b0;
         s_q <= '0;
         sw_q <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         m_q <= m_d;
         mw_q <= mw_d;
         s_q <= s_d;
         sw_q <= sw_d;
         in_ready_q <= in_ready_d;
      end
   end
endmodule

// File: tb/tb_addr_gen_pipe.sv
// tb_addr_gen_pipe: directed and randomized checks of addr_gen_pipe against an arithmetic model feeding a FIFO scoreboard.
module tb_addr_gen_pipe;
   localparam int W = 16;
   logic Clk = 1'b0, Reset;
   logic in_valid, in_ready, addr1_sel, out_valid, out_ready, addr_wrap;
   logic [W-1:0] ir, pc, base_r, addr_out;
   logic [1:0] addr2_sel;
   int checks = 0, errors = 0;
   logic [W:0] q[$];

   always #5 Clk = ~Clk;

   addr_gen_pipe #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .ir(ir), .pc(pc), .base_r(base_r), .addr2_sel(addr2_sel), .addr1_sel(addr1_sel),
      .out_valid(out_valid), .out_ready(out_ready), .addr_out(addr_out), .addr_wrap(addr_wrap)
   );

   // Returns {wrap, address} computed with signed integer arithmetic.
   function automatic logic [W:0] model(input logic [W-1:0] ir_v, pc_v, base_v, input logic [1:0] s2, input logic s1);
      longint f, sum;
      int fw;
      logic [W-1:0] o;
      fw = s2 == 2'd1 ? 6 : s2 == 2'd2 ? 9 : 11;
      f = s2 == 2'd0 ? 0 : (longint'(ir_v) & ((longint'(1) << fw) - 1));
      if (s2 != 2'd0 && ((f >> (fw - 1)) & 1) != 0) f = f - (longint'(1) << fw);
`ifdef ADDR_LSHF1_EN
      f = f * 2;
`endif
      o = f[W-1:0];
      sum = longint'(s1 ? base_v : pc_v) + longint'(o);
      return {sum[W] ^ o[W-1], sum[W-1:0]};
   endfunction

   task automatic step(input logic iv, orr, input logic [W-1:0] ir_v, pc_v, base_v, input logic [1:0] s2, input logic s1);
      bit acc, con;
      in_valid = iv; out_ready = orr; ir = ir_v; pc = pc_v; base_r = base_v; addr2_sel = s2; addr1_sel = s1;
      acc = iv && q.size() < 2;
      con = orr && q.size() > 0;
      @(posedge Clk);
      #1;
      if (con) void'(q.pop_front());
      if (acc) q.push_back(model(ir_v, pc_v, base_v, s2, s1));
   endtask

   task automatic test_reset;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || addr_out !== '0 || addr_wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_init got v=%b r=%b a=%h w=%b exp v=0 r=1 a=0 w=0", out_valid, in_ready, addr_out, addr_wrap);
      end
      #2 Reset = 1'b0;
      step(1, 0, 16'h0000, 16'h1111, 16'h0, 2'd0, 1'b0);
      step(1, 0, 16'h0000, 16'h2222, 16'h0, 2'd0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || addr_out !== 16'h1111) begin
         errors++;
         $display("FAIL reset_fill_two got r=%b a=%h exp r=0 a=1111", in_ready, addr_out);
      end
      #3 Reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || addr_out !== '0 || addr_wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got v=%b r=%b a=%h w=%b exp v=0 r=1 a=0 w=0", out_valid, in_ready, addr_out, addr_wrap);
      end
      q.delete();
      #1 Reset = 1'b0;
      step(1, 0, 16'h0000, 16'h0042, 16'h0, 2'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || addr_out !== 16'h0042) begin
         errors++;
         $display("FAIL reset_first_accept got v=%b a=%h exp v=1 a=0042", out_valid, addr_out);
      end
      step(0, 1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
   endtask

   task automatic test_directed;
      logic [W-1:0] e3, e4b, e2;
`ifdef ADDR_LSHF1_EN
      e2 = 16'h2FFE; e3 = 16'h0008; e4b = 16'h0A34;
`else
      e2 = 16'h2FFF; e3 = 16'h0003; e4b = 16'h0E34;
`endif
      step(1, 1, 16'h01FF, 16'h3000, 16'h0, 2'b10, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || addr_out !== e2 || addr_wrap !== 1'b0) begin
         errors++;
         $display("FAIL pcoff9_neg got v=%b a=%h w=%b exp v=1 a=%h w=0", out_valid, addr_out, addr_wrap, e2);
      end
      step(1, 1, 16'h0005, 16'h0, 16'hFFFE, 2'b01, 1'b1);
      checks++;
      if (addr_out !== e3 || addr_wrap !== 1'b1) begin
         errors++;
         $display("FAIL off6_wrap got a=%h w=%b exp a=%h w=1", addr_out, addr_wrap, e3);
      end
      step(1, 1, 16'hFFFF, 16'h1234, 16'h0, 2'b00, 1'b0);
      checks++;
      if (addr_out !== 16'h1234 || addr_wrap !== 1'b0) begin
         errors++;
         $display("FAIL sel_zero got a=%h w=%b exp a=1234 w=0", addr_out, addr_wrap);
      end
      step(1, 1, 16'h0400, 16'h1234, 16'h0, 2'b11, 1'b0);
      checks++;
      if (addr_out !== e4b || addr_wrap !== 1'b0) begin
         errors++;
         $display("FAIL pcoff11_neg got a=%h w=%b exp a=%h w=0", addr_out, addr_wrap, e4b);
      end
      step(0, 1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL directed_drain got v=%b exp v=0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [W:0] ea, eb, ec;
      ea = model(16'h0010, 16'h4000, 16'h0, 2'b01, 1'b0);
      eb = model(16'h0100, 16'h0, 16'h8000, 2'b10, 1'b1);
      ec = model(16'h07FF, 16'h0001, 16'h0, 2'b11, 1'b0);
      step(1, 0, 16'h0010, 16'h4000, 16'h0, 2'b01, 1'b0);
      step(1, 0, 16'h0100, 16'h0, 16'h8000, 2'b10, 1'b1);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full got r=%b v=%b exp r=0 v=1", in_ready, out_valid);
      end
      step(1, 0, 16'h07FF, 16'h0001, 16'h0, 2'b11, 1'b0);
      checks++;
      if ({addr_wrap, addr_out} !== ea || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall got %h r=%b exp %h r=0", {addr_wrap, addr_out}, in_ready, ea);
      end
      step(1, 1, 16'h07FF, 16'h0001, 16'h0, 2'b11, 1'b0);
      checks++;
      if ({addr_wrap, addr_out} !== eb || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_second got %h v=%b exp %h v=1", {addr_wrap, addr_out}, out_valid, eb);
      end
      step(1, 1, 16'h07FF, 16'h0001, 16'h0, 2'b11, 1'b0);
      checks++;
      if ({addr_wrap, addr_out} !== ec || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_third got %h v=%b exp %h v=1", {addr_wrap, addr_out}, out_valid, ec);
      end
      step(0, 1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got v=%b exp v=0", out_valid);
      end
   endtask

   task automatic test_stream;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 16'hFFFF, W'(i), 16'h0, 2'b00, 1'b0);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || addr_out !== W'(i)) begin
            errors++;
            $display("FAIL stream_%0d got r=%b v=%b a=%h exp r=1 v=1 a=%h", i, in_ready, out_valid, addr_out, W'(i));
         end
      end
      step(0, 1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), W'($urandom), W'($urandom),
              W'($urandom), 2'($urandom), 1'($urandom));
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
             (q.size() > 0 && {addr_wrap, addr_out} !== q[0])) begin
            errors++;
            $display("FAIL random_%0d got v=%b r=%b d=%h exp v=%b r=%b d=%h", i, out_valid, in_ready,
                     {addr_wrap, addr_out}, q.size() > 0, q.size() < 2, q.size() > 0 ? q[0] : 17'h0);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ir = '0; pc = '0; base_r = '0;
      addr2_sel = 2'b00; addr1_sel = 1'b0;
      #11;
      test_reset;
      test_directed;
      test_back_to_back;
      test_stream;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
